// File: rtl/aes_pkg.sv
// aes_pkg: shared AES inverse-cipher constants, GF(2^8) helpers and the FSM state type.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: aes_fsm_e, INV_SBOX, nr_from_nk(), gf_mul_x2/x9/xb/xd/xe().
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_fsm_e;

  // Inverse S-box, indexed by the input byte value.
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Number of rounds for a key of nk 32-bit words.
  function automatic int nr_from_nk(input int nk);
    return nk + 6;
  endfunction

  // Multiply by x in GF(2^8), reduction polynomial 0x11B.
  function automatic logic [7:0] gf_mul_x2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul_x4(input logic [7:0] b);
    return gf_mul_x2(gf_mul_x2(b));
  endfunction

  function automatic logic [7:0] gf_mul_x8(input logic [7:0] b);
    return gf_mul_x2(gf_mul_x4(b));
  endfunction

  function automatic logic [7:0] gf_mul_x9(input logic [7:0] b);
    return gf_mul_x8(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_xb(input logic [7:0] b);
    return gf_mul_x8(b) ^ gf_mul_x2(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_xd(input logic [7:0] b);
    return gf_mul_x8(b) ^ gf_mul_x4(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_xe(input logic [7:0] b);
    return gf_mul_x8(b) ^ gf_mul_x4(b) ^ gf_mul_x2(b);
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: one AES inverse round (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller registers the result.
// Ports: state_in/round_key (128b) in, last (skip InvMixColumns) in, state_out (128b) out.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [127:0] shifted;
  logic [127:0] subbed;
  logic [127:0] keyed;
  logic [127:0] mixed;

  // One column (4 bytes, row 0 in the MSBs) through InvMixColumns.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {gf_mul_xe(a0) ^ gf_mul_xb(a1) ^ gf_mul_xd(a2) ^ gf_mul_x9(a3),
            gf_mul_x9(a0) ^ gf_mul_xe(a1) ^ gf_mul_xb(a2) ^ gf_mul_xd(a3),
            gf_mul_xd(a0) ^ gf_mul_x9(a1) ^ gf_mul_xe(a2) ^ gf_mul_xb(a3),
            gf_mul_xb(a0) ^ gf_mul_xd(a1) ^ gf_mul_x9(a2) ^ gf_mul_xe(a3)};
  endfunction

  // Byte index 4*col+row lives at bits [127-8*idx -: 8]. Row r is rotated
  // right by r columns: out(r,c) = in(r, (c-r) mod 4).
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127 - 8*(4*c + r) -: 8] = state_in[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
      end
    end
  end

  always_comb begin
    subbed = '0;
    for (int i = 0; i < 16; i++) begin
      subbed[127 - 8*i -: 8] = INV_SBOX[shifted[127 - 8*i -: 8]];
    end
  end

  assign keyed = subbed ^ round_key;

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127 - 32*c -: 32] = inv_mix_col(keyed[127 - 32*c -: 32]);
    end
  end

  assign state_out = last ? keyed : mixed;

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// aes_inv_cipher_iter: iterative AES-128/192/256 decryptor, one shared inverse-round datapath.
// Latency: NR+1 cycles accept-to-out_valid; initiation interval NR+2 with out_ready high.
// Backpressure: in_ready only in IDLE; DONE holds out_data/out_valid until out_ready.
// Ports: clk, rst_n, flush; in_valid/in_ready/in_data; rk_idx/rk_data (key store);
//        out_valid/out_ready/out_data; busy (ROUND or DONE).
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int         NR     = nr_from_nk(NK);
  localparam logic [3:0] NR_IDX = 4'(NR);

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("aes_inv_cipher_iter: NK must be 4, 6 or 8");
  end

  aes_fsm_e     fsm;
  logic [127:0] state;
  logic [3:0]   rcnt;
  logic [127:0] round_out;

  aes_inv_round u_round (
    .state_in  (state),
    .round_key (rk_data),
    .last      (rcnt == 4'd0),
    .state_out (round_out)
  );

  // rk_idx is registered alongside the state so the key-store address is
  // stable for the whole cycle; it always holds the index the next cycle's
  // work needs (NR while idle/done, rcnt while in ROUND).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      state     <= '0;
      rcnt      <= '0;
      out_data  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      rk_idx    <= NR_IDX;
    end else if (flush) begin
      // Abort wins over every transition; out_data is deliberately kept.
      fsm       <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      rk_idx    <= NR_IDX;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid && in_ready) begin
            state    <= in_data ^ rk_data;
            rcnt     <= NR_IDX - 4'd1;
            rk_idx   <= NR_IDX - 4'd1;
            fsm      <= ROUND;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ROUND: begin
          if (rcnt != 4'd0) begin
            state  <= round_out;
            rcnt   <= rcnt - 4'd1;
            rk_idx <= rcnt - 4'd1;
          end else begin
            out_data  <= round_out;
            out_valid <= 1'b1;
            rk_idx    <= NR_IDX;
            fsm       <= DONE;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            fsm       <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          fsm       <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          rk_idx    <= NR_IDX;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// tb_aes_inv_cipher_iter: scoreboard bench for NK=4/6/8 instances of aes_inv_cipher_iter.
// Latency: checks NR+1 accept-to-valid and NR+2 spacing on back-to-back traffic.
// Backpressure: exercises out_ready stalls, flush and async reset mid-block.
module tb_aes_inv_cipher_iter;

  localparam logic [255:0] KEY   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam int LIMIT = 200;

  // Forward S-box for the bench's own key expansion and encryption model.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_data  [3];
  logic [127:0] rk_data  [3];
  logic [127:0] out_data [3];
  logic [3:0]   rk_idx   [3];
  logic [127:0] rk_tab   [3][16];

  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  int           acc_cyc  [3];
  int           last_hs  [3];
  logic [2:0]   ov_prev  = 3'b000;
  bit           chk_spacing = 1'b0;
  logic [127:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_inv_cipher_iter #(.NK(4 + 2*g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .rk_idx    (rk_idx[g]),
      .rk_data   (rk_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );
    assign rk_data[g] = rk_tab[g][rk_idx[g]];
  end

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  task automatic expand_key(input int d, input int nk);
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   rcon;
    logic [255:0] key;
    int           nr;
    key  = KEY;
    nr   = nk + 6;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk_tab[d][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Forward cipher reference: the bench encrypts and expects the DUT to undo it.
  function automatic logic [127:0] encrypt(input int d, input logic [127:0] pt);
    logic [127:0] s, t;
    logic [7:0]   a [4];
    int           nr;
    nr = 10 + 2*d;
    s  = pt ^ rk_tab[d][0];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[127 - 8*i -: 8] = SBOX[s[127 - 8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          s[127 - 8*(4*c + q) -: 8] = t[127 - 8*(4*((c + q) % 4) + q) -: 8];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          for (int q = 0; q < 4; q++) a[q] = s[127 - 8*(4*c + q) -: 8];
          s[127 - 32*c -: 32] = {xt(a[0]) ^ xt(a[1]) ^ a[1] ^ a[2] ^ a[3],
                                 a[0] ^ xt(a[1]) ^ xt(a[2]) ^ a[2] ^ a[3],
                                 a[0] ^ a[1] ^ xt(a[2]) ^ xt(a[3]) ^ a[3],
                                 xt(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xt(a[3])};
        end
      end
      s = s ^ rk_tab[d][r];
    end
    return s;
  endfunction

  // Called just after a rising edge. Leaves in_valid high when hold is set.
  task automatic send(input int d, input logic [127:0] ct, input logic [127:0] pt, input bit hold);
    int n;
    n = 0;
    in_data[d]  = ct;
    in_valid[d] = 1'b1;
    @(negedge clk);
    while (!in_ready[d] && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) check_eq("accept_timeout", 128'(in_ready[d]), 128'd1);
    exp_q.push_back(pt);
    acc_cyc[d] = cyc;
    @(posedge clk); #1;
    if (!hold) in_valid[d] = 1'b0;
  endtask

  task automatic wait_ov(input int d);
    int n;
    n = 0;
    while (!out_valid[d] && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) check_eq("ov_timeout", 128'(out_valid[d]), 128'd1);
  endtask

  task automatic wait_done(input int d);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && in_ready[d]) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) check_eq("drain_timeout", 128'(exp_q.size()), 128'd0);
    @(posedge clk); #1;
  endtask

  // Output monitor: latency on out_valid rise, data and spacing on handshake.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!chk_spacing) last_hs[d] = -1;
      if (rst_n && out_valid[d] && !ov_prev[d])
        check_eq("latency", 128'(cyc - acc_cyc[d]), 128'(11 + 2*d));
      if (rst_n && out_valid[d] && out_ready[d]) begin
        check_eq("q_nonempty", 128'(exp_q.size() != 0), 128'd1);
        if (exp_q.size() != 0) check_eq("data", out_data[d], exp_q.pop_front());
        if (chk_spacing) begin
          if (last_hs[d] >= 0) check_eq("spacing", 128'(cyc - last_hs[d]), 128'(12 + 2*d));
          last_hs[d] = cyc;
        end
      end
      ov_prev[d] = out_valid[d];
    end
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pt, ct;
    logic         ov_seen;
    rst_n     = 1'b0;
    flush     = 3'b000;
    in_valid  = 3'b000;
    out_ready = 3'b111;
    for (int d = 0; d < 3; d++) begin
      in_data[d] = '0;
      acc_cyc[d] = 0;
      last_hs[d] = -1;
      for (int r = 0; r < 16; r++) rk_tab[d][r] = '0;
    end
    expand_key(0, 4);
    expand_key(1, 6);
    expand_key(2, 8);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready",  128'(in_ready[0]),  128'd1);
    check_eq("rst_out_valid", 128'(out_valid[0]), 128'd0);
    check_eq("rst_busy",      128'(busy[0]),      128'd0);
    check_eq("rst_out_data",  out_data[0],        128'd0);
    check_eq("rst_rk_idx4",   128'(rk_idx[0]),    128'd10);
    check_eq("rst_rk_idx8",   128'(rk_idx[2]),    128'd14);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known-answer vectors for all three key sizes.
    send(0, CT128, PT, 1'b0); wait_done(0);
    send(1, CT192, PT, 1'b0); wait_done(1);
    send(2, CT256, PT, 1'b0); wait_done(2);

    // rk_idx walk: NR at accept, NR-1..0 through ROUND, NR again in DONE/IDLE.
    in_data[0]  = CT128;
    in_valid[0] = 1'b1;
    @(negedge clk);
    check_eq("rkseq_accept", 128'(rk_idx[0]), 128'd10);
    exp_q.push_back(PT);
    acc_cyc[0] = cyc;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    for (int k = 9; k >= 0; k--) begin
      @(negedge clk);
      check_eq("rkseq_round", 128'(rk_idx[0]), 128'(k));
    end
    @(negedge clk);
    check_eq("rkseq_done",    128'(rk_idx[0]),    128'd10);
    check_eq("rkseq_done_ov", 128'(out_valid[0]), 128'd1);
    @(negedge clk);
    check_eq("rkseq_idle",    128'(rk_idx[0]),    128'd10);
    wait_done(0);

    // Backpressure: DONE held for 20 cycles.
    pt = {$urandom, $urandom, $urandom, $urandom};
    ct = encrypt(0, pt);
    out_ready[0] = 1'b0;
    send(0, ct, pt, 1'b0);
    wait_ov(0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("bp_data",     out_data[0],        pt);
      check_eq("bp_valid",    128'(out_valid[0]), 128'd1);
      check_eq("bp_in_ready", 128'(in_ready[0]),  128'd0);
      check_eq("bp_rk_idx",   128'(rk_idx[0]),    128'd10);
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("bp_release_ov",  128'(out_valid[0]), 128'd0);
    check_eq("bp_release_rdy", 128'(in_ready[0]),  128'd1);
    wait_done(0);

    // Flush in ROUND cycle 5: the block is dropped.
    pt = {$urandom, $urandom, $urandom, $urandom};
    send(0, encrypt(0, pt), pt, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    flush[0] = 1'b1;
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    flush[0] = 1'b0;
    @(negedge clk);
    check_eq("flush_in_ready", 128'(in_ready[0]), 128'd1);
    check_eq("flush_busy",     128'(busy[0]),     128'd0);
    check_eq("flush_rk_idx",   128'(rk_idx[0]),   128'd10);
    ov_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      ov_seen = ov_seen | out_valid[0];
    end
    check_eq("flush_no_ov", 128'(ov_seen), 128'd0);
    @(posedge clk); #1;
    pt = {$urandom, $urandom, $urandom, $urandom};
    send(0, encrypt(0, pt), pt, 1'b0);
    wait_done(0);

    // A block offered together with flush is not taken.
    flush[0]    = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0]  = CT128;
    @(posedge clk); #1;
    flush[0]    = 1'b0;
    in_valid[0] = 1'b0;
    @(negedge clk);
    check_eq("flush_noacc_busy",  128'(busy[0]),     128'd0);
    check_eq("flush_noacc_ready", 128'(in_ready[0]), 128'd1);
    @(posedge clk); #1;

    // Flush coincident with the output handshake: one output only.
    pt = {$urandom, $urandom, $urandom, $urandom};
    out_ready[0] = 1'b0;
    send(0, encrypt(0, pt), pt, 1'b0);
    wait_ov(0);
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    flush[0]     = 1'b1;
    @(posedge clk); #1;
    flush[0] = 1'b0;
    @(negedge clk);
    check_eq("flushhs_ov",    128'(out_valid[0]), 128'd0);
    check_eq("flushhs_ready", 128'(in_ready[0]),  128'd1);
    repeat (3) @(negedge clk);
    check_eq("flushhs_q", 128'(exp_q.size()), 128'd0);
    @(posedge clk); #1;

    // Back-to-back random traffic, in_valid and out_ready held high.
    chk_spacing = 1'b1;
    for (int i = 0; i < 50; i++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      send(0, encrypt(0, pt), pt, i < 49);
    end
    wait_done(0);
    chk_spacing = 1'b0;

    // Asynchronous reset mid-ROUND: outputs return to reset values at once.
    pt = {$urandom, $urandom, $urandom, $urandom};
    send(0, encrypt(0, pt), pt, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check_eq("arst_in_ready",  128'(in_ready[0]),  128'd1);
    check_eq("arst_out_valid", 128'(out_valid[0]), 128'd0);
    check_eq("arst_busy",      128'(busy[0]),      128'd0);
    check_eq("arst_rk_idx",    128'(rk_idx[0]),    128'd10);
    check_eq("arst_out_data",  out_data[0],        128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, CT128, PT, 1'b0);
    wait_done(0);

    check_eq("final_q", 128'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
